// File: rtl/lda_req_arbiter.sv
// Round-robin arbiter that shares one line-draw engine among N_REQ
// requesters, latching the winning command until the engine is done.
module lda_req_arbiter #(
  parameter int N_REQ = 4,
  parameter int X_W   = 9,
  parameter int Y_W   = 8,
  parameter int C_W   = 3
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*X_W-1:0]       i_x0,
  input  logic [N_REQ*Y_W-1:0]       i_y0,
  input  logic [N_REQ*X_W-1:0]       i_x1,
  input  logic [N_REQ*Y_W-1:0]       i_y1,
  input  logic [N_REQ*C_W-1:0]       i_color,
  output logic [N_REQ-1:0]           o_ack,
  output logic [N_REQ-1:0]           o_req_done,
  output logic                       o_busy,
  output logic [$clog2(N_REQ)-1:0]   o_grant_id,
  output logic                       o_lda_start,
  output logic [X_W-1:0]             o_lda_x0,
  output logic [X_W-1:0]             o_lda_x1,
  output logic [Y_W-1:0]             o_lda_y0,
  output logic [Y_W-1:0]             o_lda_y1,
  output logic [C_W-1:0]             o_lda_color,
  input  logic                       i_lda_done
);

  localparam int G_W = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [G_W-1:0] ptr_q, ptr_d;
  logic [G_W-1:0] gnt_q;
  logic [G_W-1:0] sel;
  logic [G_W:0]   k;
  logic           found;
  logic [X_W-1:0] x0_q, x1_q;
  logic [Y_W-1:0] y0_q, y1_q;
  logic [C_W-1:0] col_q;
  logic [N_REQ-1:0] gnt_oh;

  // First pending request at or after the pointer, wrapping explicitly
  always_comb begin
    found = 1'b0;
    sel   = '0;
    k     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = {1'b0, ptr_q} + (G_W+1)'(i);
      if (k > (G_W+1)'(N_REQ-1))
        k = k - (G_W+1)'(N_REQ);
      if (!found && i_req[k[G_W-1:0]]) begin
        found = 1'b1;
        sel   = k[G_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE:    if (found) state_d = S_START;
      S_START:   state_d = S_WAIT;
      S_WAIT:    if (i_lda_done) state_d = S_RELEASE;
      S_RELEASE: begin
        state_d = S_IDLE;
        ptr_d   = (gnt_q == G_W'(N_REQ-1)) ?
                  '0 : gnt_q + G_W'(1);
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (state_q == S_IDLE && found) begin
        gnt_q <= sel;
        x0_q  <= i_x0[sel*X_W +: X_W];
        x1_q  <= i_x1[sel*X_W +: X_W];
        y0_q  <= i_y0[sel*Y_W +: Y_W];
        y1_q  <= i_y1[sel*Y_W +: Y_W];
        col_q <= i_color[sel*C_W +: C_W];
      end
    end
  end

  assign gnt_oh      = N_REQ'(1) << gnt_q;
  assign o_ack       = (state_q == S_START) ? gnt_oh : '0;
  assign o_req_done  = (state_q == S_RELEASE) ? gnt_oh : '0;
  assign o_lda_start = (state_q == S_START);
  assign o_busy      = (state_q != S_IDLE);
  assign o_grant_id  = gnt_q;
  assign o_lda_x0    = x0_q;
  assign o_lda_x1    = x1_q;
  assign o_lda_y0    = y0_q;
  assign o_lda_y1    = y1_q;
  assign o_lda_color = col_q;

endmodule
